// File: rtl/mac_dot_sequencer.sv
// Initiator-side sequencer for MAC_Unit: streams LEN operand pairs from a
// 1-cycle-latency RAM into the MAC and returns the settled dot product.
module mac_dot_sequencer #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned LEN_W   = 8,
    parameter int unsigned MAC_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [LEN_W-1:0]  len,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [31:0]       result,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [31:0]       rd_a,
    input  logic [31:0]       rd_b,
    output logic [31:0]       mac_a,
    output logic [31:0]       mac_b,
    output logic              mac_clr,
    output logic              mac_en,
    output logic              mac_mode,
    input  logic [31:0]       mac_o
);

    localparam int unsigned CNT_W = $clog2(MAC_LAT + 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   idx;
    logic [CNT_W-1:0]   cnt;
    logic               start_acc;
    logic               keep;

    // read-pipeline tags: rd_first marks pair 0 on the read cycle, pipe_* one cycle later
    logic               rd_first;
    logic               pipe_vld;
    logic               pipe_first;

    logic               busy_d, done_d, rd_en_d, rd_first_d;
    logic               pipe_vld_d, pipe_first_d, mac_clr_d, mac_en_d;
    logic [ADDR_W-1:0]  rd_addr_d;
    logic [31:0]        mac_a_d, mac_b_d, result_d;

    assign start_acc = (state == S_IDLE) && start;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; abort overrides everything outside IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = (len == '0) ? S_DONE : S_FETCH;
            S_FETCH: if (idx == len_q - LEN_W'(1)) state_nxt = S_ISSUE;
            S_ISSUE: if (cnt == CNT_W'(1)) state_nxt = S_DRAIN;
            S_DRAIN: if (cnt == CNT_W'(MAC_LAT - 1)) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (abort && (state != S_IDLE)) begin
            state_nxt = S_IDLE;
        end
    end

    // Output logic: next values for the registered outputs
    always_comb begin
        keep         = (state_nxt != S_IDLE);
        busy_d       = keep;
        done_d       = (state_nxt == S_DONE);
        rd_en_d      = (state_nxt == S_FETCH);
        rd_first_d   = (state == S_IDLE) && (state_nxt == S_FETCH);
        pipe_vld_d   = rd_en && keep;
        pipe_first_d = rd_first && keep;
        mac_clr_d    = pipe_vld && pipe_first && keep;
        mac_en_d     = pipe_vld && !pipe_first && keep;
        rd_addr_d    = rd_addr;
        mac_a_d      = mac_a;
        mac_b_d      = mac_b;
        result_d     = result;
        if (start_acc) begin
            rd_addr_d = base;
        end else if ((state == S_FETCH) && (state_nxt == S_FETCH)) begin
            rd_addr_d = rd_addr + ADDR_W'(1);
        end
        if (pipe_vld) begin
            mac_a_d = rd_a;
            mac_b_d = rd_b;
        end
        if (start_acc && (len == '0)) begin
            result_d = '0;
        end else if ((state == S_DRAIN) && (state_nxt == S_DONE)) begin
            result_d = mac_o;
        end
    end

    // Output and pipeline registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            rd_en      <= 1'b0;
            rd_first   <= 1'b0;
            pipe_vld   <= 1'b0;
            pipe_first <= 1'b0;
            mac_clr    <= 1'b0;
            mac_en     <= 1'b0;
            mac_mode   <= 1'b0;
            rd_addr    <= '0;
            mac_a      <= '0;
            mac_b      <= '0;
            result     <= '0;
        end else begin
            busy       <= busy_d;
            done       <= done_d;
            rd_en      <= rd_en_d;
            rd_first   <= rd_first_d;
            pipe_vld   <= pipe_vld_d;
            pipe_first <= pipe_first_d;
            mac_clr    <= mac_clr_d;
            mac_en     <= mac_en_d;
            mac_mode   <= busy_d;
            rd_addr    <= rd_addr_d;
            mac_a      <= mac_a_d;
            mac_b      <= mac_b_d;
            result     <= result_d;
        end
    end

    // Length latch and fetch/phase counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_q <= '0;
            idx   <= '0;
            cnt   <= '0;
        end else begin
            if (start_acc) begin
                len_q <= len;
            end
            idx <= (state == S_FETCH) ? idx + LEN_W'(1) : '0;
            cnt <= (state_nxt != state) ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Self-checking bench for mac_dot_sequencer with an operand RAM model, a MAC_Unit
// model (MAC_LAT=1) and a scoreboard of expected dot products.
module tb_mac_dot_sequencer;

    localparam int MAXK = 300;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  base = '0;
    logic [7:0]  len = '0;
    logic        abort = 1'b0;
    logic        busy, done, rd_en, mac_clr, mac_en, mac_mode;
    logic [31:0] result, mac_a, mac_b;
    logic [7:0]  rd_addr;
    logic [31:0] ra = '0;
    logic [31:0] rb = '0;
    logic [31:0] acc;

    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];

    logic [5:0]  rec_vec  [0:MAXK];
    logic [7:0]  rec_addr [0:MAXK];
    logic [31:0] rec_res  [0:MAXK];
    logic [9:0]  snap;

    logic [31:0] sb [$];
    logic [31:0] exp_res;
    logic [31:0] last_exp;
    int          checks = 0;
    int          errors = 0;

    mac_dot_sequencer dut (
        .clk(clk), .rst(rst_n), .start(start), .base(base), .len(len), .abort(abort),
        .busy(busy), .done(done), .result(result), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_a(ra), .rd_b(rb), .mac_a(mac_a), .mac_b(mac_b), .mac_clr(mac_clr),
        .mac_en(mac_en), .mac_mode(mac_mode), .mac_o(acc)
    );

    always #5 clk = ~clk;

    // Operand RAM: one-cycle read latency
    always @(posedge clk) begin
        if (rd_en) begin
            ra <= mem_a[rd_addr];
            rb <= mem_b[rd_addr];
        end
    end

    // MAC_Unit: accumulator visible the cycle after a strobe
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)        acc <= '0;
        else if (mac_clr)  acc <= mac_a * mac_b;
        else if (mac_en)   acc <= acc + mac_a * mac_b;
    end

    function automatic logic [31:0] dot(input logic [7:0] b, input int n);
        logic [31:0] s = '0;
        logic [7:0]  a;
        for (int i = 0; i < n; i++) begin
            a = b + 8'(i);
            s = s + mem_a[a] * mem_b[a];
        end
        return s;
    endfunction

    // Expected {busy,done,rd_en,mac_clr,mac_en,mac_mode} in cycle t_k of an uninterrupted op
    function automatic logic [5:0] exp_vec(input int n, input int k);
        logic b, d, r, c, e;
        b = (n == 0) ? (k == 1) : (k >= 1 && k <= n + 4);
        d = (n == 0) ? (k == 1) : (k == n + 4);
        r = (k >= 1 && k <= n);
        c = (n > 0) && (k == 3);
        e = (n > 1) && (k >= 4) && (k <= n + 2);
        return {b, d, r, c, e, b};
    endfunction

    function automatic logic [9:0] out_snap();
        return {busy, done, rd_en, mac_clr, mac_en, mac_mode,
                |rd_addr, |mac_a, |mac_b, |result};
    endfunction

    // Issues one start (sampled in t0) and records outputs mid-cycle for t1..tmaxk
    task automatic run_op(input logic [7:0] b, input logic [7:0] l, input int abort_k,
                          input int restart_k, input int rst_k, input int maxk);
        @(negedge clk);
        base  = b;
        len   = l;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= maxk; k++) begin
            @(negedge clk);
            rec_vec[k]  = {busy, done, rd_en, mac_clr, mac_en, mac_mode};
            rec_addr[k] = rd_addr;
            rec_res[k]  = result;
            abort = (k == abort_k);
            start = (k == restart_k);
            if (k == rst_k) begin
                rst_n = 1'b0;
                #1 snap = out_snap();
            end
            if (k == rst_k + 2) rst_n = 1'b1;
        end
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (out_snap() !== 10'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b want 0", out_snap());
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (out_snap() !== 10'b0) begin
            errors++;
            $display("FAIL idle_after_reset got %b want 0", out_snap());
        end
    endtask

    task automatic test_basic();
        mem_a[8'h10] = 32'hFFFF_FFF6; mem_b[8'h10] = 32'd1;
        mem_a[8'h11] = 32'd1;         mem_b[8'h11] = 32'd8;
        sb.push_back(32'hFFFF_FFFE);
        run_op(8'h10, 8'd2, 0, 0, 0, 12);
        for (int k = 1; k <= 12; k++) begin
            checks++;
            if (rec_vec[k] !== exp_vec(2, k)) begin
                errors++;
                $display("FAIL basic_t%0d got %b want %b", k, rec_vec[k], exp_vec(2, k));
            end
        end
        exp_res = sb.pop_front();
        checks++;
        if (rec_res[6] !== exp_res) begin
            errors++;
            $display("FAIL basic_result got %h want %h", rec_res[6], exp_res);
        end
    endtask

    task automatic test_len_zero();
        sb.push_back(32'd0);
        run_op(8'h33, 8'd0, 0, 0, 0, 6);
        for (int k = 1; k <= 6; k++) begin
            checks++;
            if (rec_vec[k] !== exp_vec(0, k)) begin
                errors++;
                $display("FAIL len0_t%0d got %b want %b", k, rec_vec[k], exp_vec(0, k));
            end
        end
        exp_res = sb.pop_front();
        checks++;
        if (rec_res[1] !== exp_res) begin
            errors++;
            $display("FAIL len0_result got %h want %h", rec_res[1], exp_res);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] ea [3];
        ea = '{8'hFE, 8'hFF, 8'h00};
        sb.push_back(dot(8'hFE, 3));
        run_op(8'hFE, 8'd3, 0, 0, 0, 10);
        for (int k = 1; k <= 10; k++) begin
            checks++;
            if (rec_vec[k] !== exp_vec(3, k)) begin
                errors++;
                $display("FAIL wrap_t%0d got %b want %b", k, rec_vec[k], exp_vec(3, k));
            end
        end
        for (int k = 1; k <= 3; k++) begin
            checks++;
            if (rec_addr[k] !== ea[k-1]) begin
                errors++;
                $display("FAIL wrap_addr_t%0d got %h want %h", k, rec_addr[k], ea[k-1]);
            end
        end
        exp_res = sb.pop_front();
        last_exp = exp_res;
        checks++;
        if (rec_res[7] !== exp_res) begin
            errors++;
            $display("FAIL wrap_result got %h want %h", rec_res[7], exp_res);
        end
    endtask

    task automatic test_abort();
        run_op(8'h20, 8'd4, 3, 0, 0, 10);
        for (int k = 1; k <= 10; k++) begin
            checks++;
            if (rec_vec[k] !== ((k <= 3) ? exp_vec(4, k) : 6'b0)) begin
                errors++;
                $display("FAIL abort_t%0d got %b want %b", k, rec_vec[k],
                         (k <= 3) ? exp_vec(4, k) : 6'b0);
            end
        end
        checks++;
        if (rec_res[10] !== last_exp) begin
            errors++;
            $display("FAIL abort_result_held got %h want %h", rec_res[10], last_exp);
        end
        sb.push_back(dot(8'h40, 5));
        run_op(8'h40, 8'd5, 0, 0, 0, 12);
        for (int k = 1; k <= 12; k++) begin
            checks++;
            if (rec_vec[k] !== exp_vec(5, k)) begin
                errors++;
                $display("FAIL after_abort_t%0d got %b want %b", k, rec_vec[k], exp_vec(5, k));
            end
        end
        exp_res = sb.pop_front();
        checks++;
        if (rec_res[9] !== exp_res) begin
            errors++;
            $display("FAIL after_abort_result got %h want %h", rec_res[9], exp_res);
        end
    endtask

    task automatic test_reset_mid_op();
        run_op(8'h50, 8'd4, 0, 0, 2, 10);
        checks++;
        if (snap !== 10'b0) begin
            errors++;
            $display("FAIL async_reset got %b want 0", snap);
        end
        for (int k = 3; k <= 10; k++) begin
            checks++;
            if (rec_vec[k] !== 6'b0) begin
                errors++;
                $display("FAIL rst_idle_t%0d got %b want 0", k, rec_vec[k]);
            end
        end
        sb.push_back(dot(8'h60, 2));
        run_op(8'h60, 8'd2, 0, 0, 0, 8);
        exp_res = sb.pop_front();
        checks++;
        if (rec_vec[6] !== exp_vec(2, 6) || rec_res[6] !== exp_res) begin
            errors++;
            $display("FAIL after_rst_result got %h/%b want %h/%b", rec_res[6], rec_vec[6],
                     exp_res, exp_vec(2, 6));
        end
    endtask

    task automatic test_back_to_back();
        int ndone;
        sb.push_back(dot(8'h70, 3));
        run_op(8'h70, 8'd3, 0, 2, 0, 14);
        ndone = 0;
        for (int k = 1; k <= 14; k++) begin
            ndone += int'(rec_vec[k][4]);
            checks++;
            if (rec_vec[k] !== exp_vec(3, k)) begin
                errors++;
                $display("FAIL restart_t%0d got %b want %b", k, rec_vec[k], exp_vec(3, k));
            end
        end
        checks++;
        if (ndone != 1) begin
            errors++;
            $display("FAIL restart_done_count got %0d want 1", ndone);
        end
        exp_res = sb.pop_front();
        checks++;
        if (rec_res[7] !== exp_res) begin
            errors++;
            $display("FAIL restart_result got %h want %h", rec_res[7], exp_res);
        end
        sb.push_back(dot(8'h80, 255));
        run_op(8'h80, 8'd255, 0, 0, 0, 262);
        for (int k = 1; k <= 262; k++) begin
            checks++;
            if (rec_vec[k] !== exp_vec(255, k)) begin
                errors++;
                $display("FAIL maxlen_t%0d got %b want %b", k, rec_vec[k], exp_vec(255, k));
            end
        end
        checks++;
        if (rec_addr[128] !== 8'hFF || rec_addr[129] !== 8'h00) begin
            errors++;
            $display("FAIL maxlen_wrap got %h,%h want ff,00", rec_addr[128], rec_addr[129]);
        end
        exp_res = sb.pop_front();
        checks++;
        if (rec_res[259] !== exp_res) begin
            errors++;
            $display("FAIL maxlen_result got %h want %h", rec_res[259], exp_res);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_left got %0d want 0", sb.size());
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = $urandom;
            mem_b[i] = $urandom;
        end
        test_reset();
        test_basic();
        test_len_zero();
        test_wrap();
        test_abort();
        test_reset_mid_op();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
